// File: rtl/change_event_counter.sv
// Change-event counter: detects value changes on NCH watched channels and credits
// LISTENERS counts per changed channel to a shared wrap/saturate counter with snapshot.
module change_event_counter #(
  parameter int WIDTH     = 32,
  parameter int NCH       = 2,
  parameter int LISTENERS = 2,
  parameter int CNT_W     = 32,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NCH*WIDTH-1:0] data_in,
  input  logic                 clear,
  input  logic                 snap_req,
  output logic [CNT_W-1:0]     cnt,
  output logic [NCH-1:0]       chg_mask,
  output logic [CNT_W-1:0]     snap_val,
  output logic                 snap_valid,
  output logic                 ovf
);

  localparam int INC_MAX = NCH * LISTENERS;
  // Extra headroom so the overflow test sees the untruncated sum.
  localparam int EXT_W = CNT_W + $clog2(INC_MAX + 1);
  localparam logic [EXT_W-1:0] MAX_EXT = {{(EXT_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [WIDTH-1:0] r_prev [NCH];
  logic [NCH-1:0]   w_chg;
  logic [EXT_W-1:0] w_pop;
  logic [EXT_W-1:0] w_inc;
  logic [EXT_W-1:0] w_sum;
  logic             w_ovf_hit;
  logic [CNT_W-1:0] w_cnt_next;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_chg = '0;
    w_pop = '0;
    for (int i = 0; i < NCH; i++) begin
      w_chg[i] = en && (data_in[i*WIDTH +: WIDTH] != r_prev[i]);
      w_pop    = w_pop + EXT_W'(w_chg[i]);
    end
    w_inc     = w_pop * EXT_W'(LISTENERS);
    w_sum     = EXT_W'(cnt) + w_inc;
    w_ovf_hit = (w_sum > MAX_EXT);
    if (clear)
      w_cnt_next = '0;
    else if (SATURATE && w_ovf_hit)
      w_cnt_next = '1;
    else
      w_cnt_next = w_sum[CNT_W-1:0];
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values; prev[] is a small register bank, so it is reset like the rest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      chg_mask   <= '0;
      snap_val   <= '0;
      snap_valid <= 1'b0;
      ovf        <= 1'b0;
      for (int i = 0; i < NCH; i++) r_prev[i] <= '0;
    end else begin
      if (en)
        for (int i = 0; i < NCH; i++) r_prev[i] <= data_in[i*WIDTH +: WIDTH];
      cnt        <= w_cnt_next;
      chg_mask   <= w_chg;
      snap_valid <= snap_req;
      if (snap_req) snap_val <= w_cnt_next;
      if (clear)
        ovf <= 1'b0;
      else if (w_ovf_hit)
        ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_change_event_counter.sv
// Directed bench for change_event_counter: default 32-bit instance plus 4-bit wrap
// and 4-bit saturate instances sharing one stimulus stream.
module tb_change_event_counter;

  logic        clk = 1'b0;
  logic        rst_n, en, clear, snap_req;
  logic [31:0] ch0, ch1;
  logic [63:0] data_in;
  assign data_in = {ch1, ch0};

  logic [31:0] cnt, snap_val;
  logic [1:0]  chg_mask, w_chg_mask, s_chg_mask;
  logic        snap_valid, ovf;
  logic [3:0]  w_cnt, w_snap_val, s_cnt, s_snap_val;
  logic        w_snap_valid, w_ovf, s_snap_valid, s_ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  change_event_counter dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .clear(clear),
    .snap_req(snap_req), .cnt(cnt), .chg_mask(chg_mask), .snap_val(snap_val),
    .snap_valid(snap_valid), .ovf(ovf)
  );

  change_event_counter #(.CNT_W(4), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .clear(clear),
    .snap_req(snap_req), .cnt(w_cnt), .chg_mask(w_chg_mask), .snap_val(w_snap_val),
    .snap_valid(w_snap_valid), .ovf(w_ovf)
  );

  change_event_counter #(.CNT_W(4), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .clear(clear),
    .snap_req(snap_req), .cnt(s_cnt), .chg_mask(s_chg_mask), .snap_val(s_snap_val),
    .snap_valid(s_snap_valid), .ovf(s_ovf)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; snap_req = 1'b0; ch0 = '0; ch1 = '0;
    repeat (3) tick();
    rst_n = 1'b1; en = 1'b1;
    tick();
    check("rst_cnt", cnt, 0);
    check("rst_chg", chg_mask, 2'b00);
    check("rst_ovf", ovf, 0);
    check("rst_snapv", snap_valid, 0);
    check("rst_snapval", snap_val, 0);

    for (int s = 1; s <= 9; s++) begin
      ch0 = s;
      tick();
      check("ramp_cnt", cnt, 2 * s);
      check("ramp_chg", chg_mask, 2'b01);
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      check("ramp_snapv", snap_valid, 1);
      check("ramp_snapval", snap_val, 2 * s);
      repeat (8) tick();
      check("ramp_snapv_drop", snap_valid, 0);
      check("ramp_hold", cnt, 2 * s);
    end
    check("ramp_final", cnt, 18);

    // Both channels change with a same-cycle snapshot: 18 + 4.
    ch0 = 10; ch1 = 1; snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    check("sim_cnt", cnt, 22);
    check("sim_chg", chg_mask, 2'b11);
    check("sim_snapval", snap_val, 22);
    check("sim_snapv", snap_valid, 1);

    en = 1'b0; ch0 = 100; ch1 = 200;
    tick();
    check("dis_cnt", cnt, 22);
    check("dis_chg", chg_mask, 2'b00);
    ch0 = 10; ch1 = 77;
    tick();
    check("dis_cnt2", cnt, 22);
    en = 1'b1;
    tick();
    check("reen_cnt", cnt, 24);
    check("reen_chg", chg_mask, 2'b10);
    tick();
    check("const_cnt", cnt, 24);
    check("const_chg", chg_mask, 2'b00);

    snap_req = 1'b1; ch0 = 11;
    tick();
    check("b2b_snapval1", snap_val, 26);
    check("b2b_snapv1", snap_valid, 1);
    ch0 = 12;
    tick();
    check("b2b_snapval2", snap_val, 28);
    check("b2b_snapv2", snap_valid, 1);
    check("b2b_cnt", cnt, 28);
    snap_req = 1'b0;
    tick();
    check("b2b_snapv_end", snap_valid, 0);

    clear = 1'b1; snap_req = 1'b1; ch0 = 13;
    tick();
    clear = 1'b0; snap_req = 1'b0;
    check("clr_cnt", cnt, 0);
    check("clr_snapval", snap_val, 0);
    check("clr_snapv", snap_valid, 1);
    check("clr_ovf", ovf, 0);
    check("clr_chg", chg_mask, 2'b01);
    tick();
    check("clr_snapv_drop", snap_valid, 0);
    check("clr_prev_upd", cnt, 0);
    check("clr_w_ovf", w_ovf, 0);
    check("clr_s_cnt", s_cnt, 0);

    for (int k = 0; k < 7; k++) begin
      ch0 = 14 + k;
      tick();
    end
    check("pre_w_cnt", w_cnt, 14);
    check("pre_s_cnt", s_cnt, 14);
    ch0 = 21;
    tick();
    check("wrap_cnt", w_cnt, 0);
    check("wrap_ovf", w_ovf, 1);
    check("wide_cnt", cnt, 16);
    check("wide_ovf", ovf, 0);
    check("sat1_cnt", s_cnt, 15);
    ch0 = 22;
    tick();
    check("wrap_cnt2", w_cnt, 2);
    check("wrap_ovf_sticky", w_ovf, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("wrap_clr_cnt", w_cnt, 0);
    check("wrap_clr_ovf", w_ovf, 0);
    check("sat_clr_ovf", s_ovf, 0);

    for (int k = 0; k < 7; k++) begin
      ch0 = 23 + k;
      tick();
    end
    check("sat_pre_cnt", s_cnt, 14);
    check("sat_pre_ovf", s_ovf, 0);
    ch0 = 30; ch1 = 78;
    tick();
    check("sat_cnt", s_cnt, 15);
    check("sat_ovf", s_ovf, 1);
    check("sat_chg", s_chg_mask, 2'b11);
    check("wrap2_cnt", w_cnt, 2);
    ch1 = 79;
    tick();
    check("sat_hold", s_cnt, 15);
    check("sat_ovf_sticky", s_ovf, 1);

    snap_req = 1'b1;
    tick();
    check("sat_snapv", s_snap_valid, 1);
    check("sat_snapval", s_snap_val, 15);
    rst_n = 1'b0;
    tick();
    check("rstmid_snapv", s_snap_valid, 0);
    check("rstmid_cnt", s_cnt, 0);
    check("rstmid_ovf", s_ovf, 0);
    check("rstmid_snapval", s_snap_val, 0);
    check("rstmid_chg", chg_mask, 2'b00);
    rst_n = 1'b1; snap_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/change_event_counter.md
Name: change_event_counter

Overview:
- Parametrised, synthesizable change-event counter for the CPU design.
- Watches NCH data channels and detects any value change on each clock edge.
- Credits LISTENERS counts per changed channel to a shared counter, modelling LISTENERS independent observers that each react to every change.
- Provides a snapshot port that captures the counter after the same cycle's updates have settled. Used to count update events on shared result buses and status words.

Parameters:
- WIDTH, 32, bits per watched channel
- NCH, 2, number of watched channels
- LISTENERS, 2, counts credited per detected change (≥1)
- CNT_W, 32, counter width
- SATURATE, 0, 0 = counter wraps modulo 2^CNT_W; 1 = counter clamps at 2^CNT_W-1

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  sampling enable; when low, no detection and prev[] holds
- data_in  in  NCH*WIDTH  channel i = data_in[i*WIDTH +: WIDTH]
- clear  in  1  zero the counter and ovf
- snap_req  in  1  request a snapshot of the post-update count
- cnt  out  CNT_W  running count (registered)
- chg_mask  out  NCH  registered per-channel change flags from the last cycle
- snap_val  out  CNT_W  captured count
- snap_valid  out  1  one-cycle pulse when snap_val is updated
- ovf  out  1  sticky: set on wrap (SATURATE=0) or clamp (SATURATE=1)

Behaviour:
- Reset (rst_n=0 at a clk edge): cnt=0, chg_mask=0, snap_val=0, snap_valid=0, ovf=0, all prev[i]=0.
  - Reset overrides all other inputs, including mid-snapshot; a pending snap_valid is dropped.
- Change detect (combinational): chg[i] = en & (data_in[i] != prev[i]).
  - prev[i] <= data_in[i] on every cycle with en=1, whether or not the channel changed.
  - First enabled cycle after reset compares against 0, so nonzero inputs count as changes.
- Increment: inc = popcount(chg) * LISTENERS.
  - Computed at CNT_W+$clog2(NCH*LISTENERS+1) bits; no truncation before the overflow check.
- Next count: sum = cnt + inc, computed at the extended width.
  - SATURATE=0: cnt_next = sum mod 2^CNT_W; ovf set if sum ≥ 2^CNT_W.
  - SATURATE=1: cnt_next = min(sum, 2^CNT_W-1); ovf set if sum > 2^CNT_W-1.
  - ovf stays set until clear or reset.
- clear=1: cnt_next=0 and ovf<=0.
  - Events in the same cycle are discarded.
  - prev[] still updates per en.
- chg_mask <= chg every cycle; it is 0 when en=0.
- Snapshot: when snap_req=1, snap_val <= cnt_next, i.e. the value that includes this cycle's events, or 0 if clear is also asserted.
  - snap_valid=1 in the following cycle only.
  - Back-to-back snap_req gives snap_valid high continuously, with a fresh value each cycle.
- Latency: an input change at edge k is visible on cnt and chg_mask after edge k; a snapshot requested at edge k appears on snap_val after edge k with the same value as cnt.
- Simultaneous changes on all channels in one cycle credit NCH*LISTENERS at once; no event is lost.
- Holding data_in constant generates no events regardless of en.

Test Plan:
- Reset/initial: NCH=2, LISTENERS=2; hold rst_n=0 for 3 cycles, then data_in=0, en=1 → cnt=0, chg_mask=00, ovf=0, snap_valid=0.
- Single-channel ramp:
  - Stimulus: channel 0 increments every 10 cycles for 9 steps; snap_req one cycle after each step.
  - Response: cnt steps 2,4,…,18; snap_val matches cnt at each step; final cnt=18.
- Simultaneous events: change both channels in one cycle → cnt +4, chg_mask=11; en=0 with changing data → cnt unchanged; re-enable → one change counted per channel that differs from prev.
- Clear collision: clear, snap_req and a channel change in the same cycle → cnt=0, snap_val=0, snap_valid next cycle, ovf=0.
- Wrap: CNT_W=4, SATURATE=0, cnt=14, one change → cnt=0, ovf=1; ovf stays 1 until clear.
- Saturate: CNT_W=4, SATURATE=1, cnt=14, both channels change → cnt=15, ovf=1; further changes keep cnt=15; rst_n=0 mid-snapshot → snap_valid=0.
